proc_run_ctrl: RTL and testbench

- Synthesisable run controller placed between the board/bench clock-reset source and the Processor core.
- Sequences the core's reset on a start request and counts execution cycles.
- Records every change of the core's 32-bit result bus into a small trace FIFO.
- Ends the run on halt detection (result stable for a programmable number of cycles) or on a cycle timeout.

---
 rtl/proc_run_ctrl_pkg.sv | 18 +
 rtl/trace_fifo.sv | 65 ++++++
 rtl/proc_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_proc_run_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/proc_run_ctrl_pkg.sv
// Shared types and width helpers for the processor run controller.
package proc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReset = 2'd1,
    StRun   = 2'd2,
    StStop  = 2'd3
  } state_e;

  localparam int unsigned CycleW = 32;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO with sticky overflow flag and synchronous clear.
module trace_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   pop,
  output logic [DATA_W-1:0]      data_out,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] LvlOne = (AddrW + 1)'(1);
  localparam logic [AddrW-1:0] PtrOne = AddrW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]    level_q;
  logic              overflow_q;
  logic              do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == (AddrW + 1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlOne;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LvlOne;
      end
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: sequences core reset, counts run cycles, traces result changes,
// and stops the run on halt (stable result) or cycle timeout.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned TRACE_DEPTH   = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            result,
  output logic                         core_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic [CycleW-1:0]            cycle_count,
  input  logic                         trace_rd_en,
  output logic [DATA_W-1:0]            trace_data,
  output logic                         trace_empty,
  output logic [$clog2(TRACE_DEPTH):0] trace_level,
  output logic                         trace_overflow
);

  localparam int unsigned StableW = cnt_width(STABLE_CYCLES);
  localparam int unsigned RstW    = cnt_width(RST_CYCLES);

  state_e              state_q, state_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [StableW-1:0]  stable_q, stable_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                first_q, first_d;
  logic [CycleW-1:0]   cycle_q, cycle_d;
  logic                done_q, done_d;
  logic                timed_out_q, timed_out_d;
  logic                fifo_clear, push;
  logic                unused_fifo_full;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stable_d    = stable_q;
    prev_d      = prev_q;
    first_d     = first_q;
    cycle_d     = cycle_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    fifo_clear  = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle, StStop: begin
        if (start) begin
          state_d     = StReset;
          rst_cnt_d   = RstW'(RST_CYCLES - 1);
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          cycle_d     = '0;
          fifo_clear  = 1'b1;
        end
      end
      StReset: begin
        if (rst_cnt_q == '0) begin
          state_d = StRun;
          first_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q - RstW'(1);
        end
      end
      StRun: begin
        first_d = 1'b0;
        if (cycle_q != '1) cycle_d = cycle_q + CycleW'(1);
        if (first_q || (result != prev_q)) begin
          push     = 1'b1;
          prev_d   = result;
          stable_d = StableW'(1);
        end else begin
          stable_d = stable_q + StableW'(1);
        end
        // Halt takes priority when both end conditions land on the same cycle.
        if (stable_d == StableW'(STABLE_CYCLES)) begin
          state_d = StStop;
          done_d  = 1'b1;
        end else if (cycle_d == CycleW'(TIMEOUT)) begin
          state_d     = StStop;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign core_reset  = (state_q != StRun);
  assign busy        = (state_q == StReset) || (state_q == StRun);
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_q;

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (push),
    .data_in  (result),
    .pop      (trace_rd_en),
    .data_out (trace_data),
    .empty    (trace_empty),
    .full     (unused_fifo_full),
    .level    (trace_level),
    .overflow (trace_overflow)
  );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: reset, halt, timeout, halt/timeout tie, full FIFO, restart.
module tb_proc_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start, start_b;
  logic [31:0] result, result_b;
  logic        core_reset, core_reset_b;
  logic        busy, busy_b;
  logic        done, done_b;
  logic        timed_out, timed_out_b;
  logic [31:0] cycle_count, cycle_count_b;
  logic        trace_rd_en, trace_rd_en_b;
  logic [31:0] trace_data, trace_data_b;
  logic        trace_empty, trace_empty_b;
  logic [3:0]  trace_level, trace_level_b;
  logic        trace_overflow, trace_overflow_b;

  int tests;
  int failed;

  proc_run_ctrl #(
    .DATA_W(32), .RST_CYCLES(2), .TRACE_DEPTH(8), .STABLE_CYCLES(16), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .result(result), .core_reset(core_reset),
    .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count),
    .trace_rd_en(trace_rd_en), .trace_data(trace_data), .trace_empty(trace_empty),
    .trace_level(trace_level), .trace_overflow(trace_overflow)
  );

  // Halt and timeout coincide on the 16th run cycle.
  proc_run_ctrl #(
    .DATA_W(32), .RST_CYCLES(2), .TRACE_DEPTH(8), .STABLE_CYCLES(16), .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .result(result_b), .core_reset(core_reset_b),
    .busy(busy_b), .done(done_b), .timed_out(timed_out_b), .cycle_count(cycle_count_b),
    .trace_rd_en(trace_rd_en_b), .trace_data(trace_data_b), .trace_empty(trace_empty_b),
    .trace_level(trace_level_b), .trace_overflow(trace_overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #12;
    tests++; if (core_reset !== 1'b1) begin failed++; $display("FAIL rst_core_reset got %0b want 1", core_reset); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0 || timed_out !== 1'b0) begin failed++; $display("FAIL rst_flags got %0b%0b want 00", done, timed_out); end
    tests++; if (cycle_count !== 32'd0) begin failed++; $display("FAIL rst_count got %0d want 0", cycle_count); end
    tests++; if (trace_empty !== 1'b1 || trace_level !== 4'd0) begin failed++; $display("FAIL rst_fifo got empty=%0b level=%0d want 1/0", trace_empty, trace_level); end
    tests++; if (trace_data !== 32'd0 || trace_overflow !== 1'b0) begin failed++; $display("FAIL rst_data got %0h/%0b want 0/0", trace_data, trace_overflow); end
    #8;
    reset = 1'b1;
  endtask

  task automatic test_start_and_midrun_reset();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (core_reset !== 1'b1 || busy !== 1'b1) begin failed++; $display("FAIL seq_rst1 got core_reset=%0b busy=%0b want 1/1", core_reset, busy); end
    tick();
    tests++; if (core_reset !== 1'b1 || busy !== 1'b1) begin failed++; $display("FAIL seq_rst2 got core_reset=%0b busy=%0b want 1/1", core_reset, busy); end
    tick();
    tests++; if (core_reset !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL seq_run got core_reset=%0b busy=%0b want 0/1", core_reset, busy); end
    result = 32'h11;
    tick();
    tests++; if (cycle_count !== 32'd1) begin failed++; $display("FAIL seq_first_count got %0d want 1", cycle_count); end
    for (int i = 0; i < 4; i++) begin
      result = 32'h20 + 32'(i);
      tick();
    end
    tests++; if (trace_level !== 4'd5 || cycle_count !== 32'd5) begin failed++; $display("FAIL seq_level got level=%0d count=%0d want 5/5", trace_level, cycle_count); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (core_reset !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL mid_rst_ctrl got core_reset=%0b busy=%0b want 1/0", core_reset, busy); end
    tests++; if (cycle_count !== 32'd0 || trace_level !== 4'd0 || trace_empty !== 1'b1) begin failed++; $display("FAIL mid_rst_state got count=%0d level=%0d empty=%0b want 0/0/1", cycle_count, trace_level, trace_empty); end
    tests++; if (trace_data !== 32'd0) begin failed++; $display("FAIL mid_rst_data got %0h want 0", trace_data); end
    #2;
    reset = 1'b1;
  endtask

  task automatic test_halt();
    logic [31:0] exp_vals [3];
    exp_vals = '{32'd0, 32'd5, 32'd9};
    enter_run();
    result = 32'd0; tick();
    result = 32'd5; tick(); tick();
    result = 32'd9;
    for (int i = 0; i < 15; i++) tick();
    tests++; if (done !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd18) begin failed++; $display("FAIL halt_pre got done=%0b busy=%0b count=%0d want 0/1/18", done, busy, cycle_count); end
    tick();
    tests++; if (done !== 1'b1 || timed_out !== 1'b0) begin failed++; $display("FAIL halt_flags got done=%0b timed_out=%0b want 1/0", done, timed_out); end
    tests++; if (cycle_count !== 32'd19) begin failed++; $display("FAIL halt_count got %0d want 19", cycle_count); end
    tests++; if (trace_level !== 4'd3 || busy !== 1'b0 || core_reset !== 1'b1) begin failed++; $display("FAIL halt_stop got level=%0d busy=%0b core_reset=%0b want 3/0/1", trace_level, busy, core_reset); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (trace_data !== exp_vals[k]) begin failed++; $display("FAIL halt_pop%0d got %0h want %0h", k, trace_data, exp_vals[k]); end
      trace_rd_en = 1'b1; tick(); trace_rd_en = 1'b0;
    end
    tests++; if (trace_empty !== 1'b1 || trace_data !== 32'd0) begin failed++; $display("FAIL halt_empty got empty=%0b data=%0h want 1/0", trace_empty, trace_data); end
    trace_rd_en = 1'b1; tick(); trace_rd_en = 1'b0;
    tests++; if (trace_level !== 4'd0 || trace_empty !== 1'b1) begin failed++; $display("FAIL halt_underflow got level=%0d empty=%0b want 0/1", trace_level, trace_empty); end
    tests++; if (cycle_count !== 32'd19 || done !== 1'b1) begin failed++; $display("FAIL halt_hold got count=%0d done=%0b want 19/1", cycle_count, done); end
  endtask

  task automatic test_timeout();
    enter_run();
    for (int i = 0; i < 49; i++) begin
      result = 32'h1000 + 32'(i);
      tick();
    end
    tests++; if (timed_out !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd49) begin failed++; $display("FAIL to_pre got timed_out=%0b busy=%0b count=%0d want 0/1/49", timed_out, busy, cycle_count); end
    result = 32'h1000 + 32'd49;
    tick();
    tests++; if (cycle_count !== 32'd50 || timed_out !== 1'b1 || done !== 1'b0) begin failed++; $display("FAIL to_stop got count=%0d timed_out=%0b done=%0b want 50/1/0", cycle_count, timed_out, done); end
    tests++; if (trace_overflow !== 1'b1 || trace_level !== 4'd8 || busy !== 1'b0) begin failed++; $display("FAIL to_fifo got ovf=%0b level=%0d busy=%0b want 1/8/0", trace_overflow, trace_level, busy); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (trace_data !== 32'h1000 + 32'(k)) begin failed++; $display("FAIL to_pop%0d got %0h want %0h", k, trace_data, 32'h1000 + 32'(k)); end
      trace_rd_en = 1'b1; tick(); trace_rd_en = 1'b0;
    end
    tests++; if (trace_empty !== 1'b1 || cycle_count !== 32'd50) begin failed++; $display("FAIL to_drain got empty=%0b count=%0d want 1/50", trace_empty, cycle_count); end
  endtask

  task automatic test_simultaneous();
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick();
    result_b = 32'd7;
    for (int i = 0; i < 15; i++) tick();
    tests++; if (busy_b !== 1'b1 || done_b !== 1'b0) begin failed++; $display("FAIL tie_pre got busy=%0b done=%0b want 1/0", busy_b, done_b); end
    tick();
    tests++; if (done_b !== 1'b1 || timed_out_b !== 1'b0) begin failed++; $display("FAIL tie_flags got done=%0b timed_out=%0b want 1/0", done_b, timed_out_b); end
    tests++; if (cycle_count_b !== 32'd16 || trace_level_b !== 4'd1) begin failed++; $display("FAIL tie_count got count=%0d level=%0d want 16/1", cycle_count_b, trace_level_b); end
  endtask

  task automatic test_back_to_back();
    enter_run();
    tests++; if (trace_overflow !== 1'b0 || timed_out !== 1'b0 || cycle_count !== 32'd0) begin failed++; $display("FAIL b2b_clear got ovf=%0b timed_out=%0b count=%0d want 0/0/0", trace_overflow, timed_out, cycle_count); end
    for (int i = 0; i < 8; i++) begin
      result = 32'h200 + 32'(i);
      tick();
    end
    tests++; if (trace_level !== 4'd8 || trace_overflow !== 1'b0) begin failed++; $display("FAIL b2b_full got level=%0d ovf=%0b want 8/0", trace_level, trace_overflow); end
    result = 32'h300;
    trace_rd_en = 1'b1; tick(); trace_rd_en = 1'b0;
    tests++; if (trace_level !== 4'd8 || trace_overflow !== 1'b0 || trace_data !== 32'h201) begin failed++; $display("FAIL b2b_pushpop got level=%0d ovf=%0b data=%0h want 8/0/201", trace_level, trace_overflow, trace_data); end
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    tests++; if (cycle_count !== 32'd12 || busy !== 1'b1 || trace_level !== 4'd8) begin failed++; $display("FAIL b2b_start_ignored got count=%0d busy=%0b level=%0d want 12/1/8", cycle_count, busy, trace_level); end
    for (int i = 0; i < 11; i++) tick();
    tests++; if (done !== 1'b0 || cycle_count !== 32'd23) begin failed++; $display("FAIL b2b_pre_halt got done=%0b count=%0d want 0/23", done, cycle_count); end
    tick();
    tests++; if (done !== 1'b1 || cycle_count !== 32'd24 || trace_level !== 4'd8) begin failed++; $display("FAIL b2b_halt got done=%0b count=%0d level=%0d want 1/24/8", done, cycle_count, trace_level); end
    start = 1'b1; tick(); start = 1'b0;
    tests++; if (done !== 1'b0 || cycle_count !== 32'd0 || busy !== 1'b1) begin failed++; $display("FAIL restart_ctrl got done=%0b count=%0d busy=%0b want 0/0/1", done, cycle_count, busy); end
    tests++; if (trace_level !== 4'd0 || trace_empty !== 1'b1 || trace_data !== 32'd0) begin failed++; $display("FAIL restart_fifo got level=%0d empty=%0b data=%0h want 0/1/0", trace_level, trace_empty, trace_data); end
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    reset         = 1'b0;
    start         = 1'b0;
    start_b       = 1'b0;
    result        = 32'd0;
    result_b      = 32'd0;
    trace_rd_en   = 1'b0;
    trace_rd_en_b = 1'b0;
    test_reset();
    test_start_and_midrun_reset();
    test_halt();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
